pc_unit: RTL and testbench

- Parametrised, registered successor to the combinational next-PC logic.
- Holds the program counter and computes the next instruction address for sequential, branch (beq/bne), jump, jal, jr, exception and eret flow.
- Keeps an exception PC and a small return-address stack (RAS) that checks jr targets.
- Sits between the instruction-fetch address port and the decode/control unit of the MIPS datapath.

---
 rtl/pc_unit_pkg.sv | 23 ++
 rtl/pc_unit_ras_stack.sv | 44 ++++
 rtl/pc_unit.sv | 95 +++++++++
 tb/tb_pc_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the registered next-PC unit.
// Covers the next-PC source select, default vectors and the branch-offset helper.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BR,
    PC_J,
    PC_JAL,
    PC_JR,
    PC_EXC,
    PC_ERET
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

  // Word offset to byte offset, sign-extended to the widest legal address.
  function automatic logic [63:0] sext_shift(input logic [15:0] imm);
    return {{46{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored. The pointer addresses the next free slot.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;

  assign empty = (count == '0);
  assign top   = mem[ptr - PW'(1)];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Contents carry no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with branch/jump/jal/jr/exception/eret sequencing,
// an exception PC and a return-address stack that flags jr mispredictions.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         bne,
  input  logic                         zero,
  input  logic                         jump,
  input  logic                         jal,
  input  logic                         jr,
  input  logic [ADDR_W-1:0]            jr_target,
  input  logic                         exc,
  input  logic                         eret,
  input  logic [15:0]                  imm16,
  input  logic [25:0]                  imm26,
  output logic [ADDR_W-1:0]            iaddr,
  output logic [ADDR_W-1:0]            pc4,
  output logic [ADDR_W-1:0]            epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_miss
);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] next_pc, br_target, j_target, ras_top;
  logic              taken, push, pop, ras_empty;

  assign pc4       = iaddr + ADDR_W'(4);
  assign br_target = pc4 + ADDR_W'(sext_shift(imm16));
  assign j_target  = {pc4[ADDR_W-1:28], imm26, 2'b00};
  assign taken     = branch & (bne ? ~zero : zero);

  always_comb begin
    sel = PC_SEQ;
    if (exc)        sel = PC_EXC;
    else if (eret)  sel = PC_ERET;
    else if (jr)    sel = PC_JR;
    else if (jal)   sel = PC_JAL;
    else if (jump)  sel = PC_J;
    else if (taken) sel = PC_BR;
  end

  always_comb begin
    next_pc = pc4;
    case (sel)
      PC_EXC:        next_pc = ADDR_W'(EXC_VECTOR);
      PC_ERET:       next_pc = epc;
      PC_JR:         next_pc = jr_target;
      PC_JAL, PC_J:  next_pc = j_target;
      PC_BR:         next_pc = br_target;
      default:       next_pc = pc4;
    endcase
  end

  // Stall freezes the stack; exc already wins the select so never pushes/pops.
  assign push = (sel == PC_JAL) & ~stall & ~rst;
  assign pop  = (sel == PC_JR)  & ~stall & ~rst;

  ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc4),
    .top   (ras_top),
    .count (ras_count),
    .empty (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      iaddr    <= ADDR_W'(RESET_PC);
      epc      <= '0;
      ras_miss <= 1'b0;
    end else if (exc) begin
      iaddr    <= next_pc;
      epc      <= iaddr;
      ras_miss <= 1'b0;
    end else if (stall) begin
      ras_miss <= 1'b0;
    end else begin
      iaddr    <= next_pc;
      ras_miss <= pop & (ras_empty | (ras_top != jr_target));
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Vector table of control/immediate inputs with hand-derived expected state,
// fed through a scoreboard queue and compared one cycle after each drive.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch, bne, zero, jump, jal, jr, exc, eret;
  logic [31:0] jr_target;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] iaddr, pc4, epc;
  logic [2:0]  ras_count;
  logic        ras_miss;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .bne(bne), .zero(zero),
    .jump(jump), .jal(jal), .jr(jr), .jr_target(jr_target), .exc(exc), .eret(eret),
    .imm16(imm16), .imm26(imm26), .iaddr(iaddr), .pc4(pc4), .epc(epc),
    .ras_count(ras_count), .ras_miss(ras_miss)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] R = 10'd1,   S = 10'd2,   B = 10'd4,   N = 10'd8,   Z = 10'd16;
  localparam logic [9:0] J = 10'd32,  L = 10'd64,  JR = 10'd128, X = 10'd256, E = 10'd512;

  typedef struct {
    logic [9:0]  c;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] jt;
    logic [31:0] ia;
    logic [31:0] ep;
    int          cnt;
    logic        miss;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic [9:0] c, input logic [15:0] i16, input logic [25:0] i26,
                     input logic [31:0] jt, input logic [31:0] ia, input logic [31:0] ep,
                     input int cnt, input logic miss);
    vec_t v;
    v.c = c; v.i16 = i16; v.i26 = i26; v.jt = jt;
    v.ia = ia; v.ep = ep; v.cnt = cnt; v.miss = miss;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
    end
  endtask

  initial begin
    vec_t v, e;
    logic [31:0] exp_pc4;
    {rst, stall, branch, bne, zero, jump, jal, jr, exc, eret} = '0;
    jr_target = '0; imm16 = '0; imm26 = '0;

    // reset and sequential
    add(R,   0, 0, 0, 32'h3000, 0, 0, 0);
    add(R,   0, 0, 0, 32'h3000, 0, 0, 0);
    add(0,   0, 0, 0, 32'h3004, 0, 0, 0);
    add(0,   0, 0, 0, 32'h3008, 0, 0, 0);
    add(0,   0, 0, 0, 32'h300C, 0, 0, 0);
    add(0,   0, 0, 0, 32'h3010, 0, 0, 0);
    // branches from 0x3010, re-centred with j
    add(B|Z,   16'hFFFC, 0, 0, 32'h3004, 0, 0, 0);
    add(J,     0, 26'hC04, 0, 32'h3010, 0, 0, 0);
    add(B,     16'hFFFC, 0, 0, 32'h3014, 0, 0, 0);
    add(J,     0, 26'hC04, 0, 32'h3010, 0, 0, 0);
    add(B|N,   16'h0003, 0, 0, 32'h3020, 0, 0, 0);
    add(J,     0, 26'hC04, 0, 32'h3010, 0, 0, 0);
    add(Z,     16'h0003, 0, 0, 32'h3014, 0, 0, 0);
    add(J,     0, 26'hC04, 0, 32'h3010, 0, 0, 0);
    add(B|N|Z, 16'h0003, 0, 0, 32'h3014, 0, 0, 0);
    add(J,     0, 26'hC00, 0, 32'h3000, 0, 0, 0);
    // jal / jr / empty pop
    add(L,  0, 26'hC40, 0,        32'h3100, 0, 1, 0);
    add(JR, 0, 0, 32'h3004,       32'h3004, 0, 0, 0);
    add(JR, 0, 0, 32'h3004,       32'h3004, 0, 0, 1);
    add(0,  0, 0, 0,              32'h3008, 0, 0, 0);
    // overflow: five pushes into four entries, then LIFO pops
    add(L,  0, 26'hC40, 0,        32'h3100, 0, 1, 0);
    add(L,  0, 26'hC80, 0,        32'h3200, 0, 2, 0);
    add(L,  0, 26'hC00, 0,        32'h3000, 0, 3, 0);
    add(L,  0, 26'hC40, 0,        32'h3100, 0, 4, 0);
    add(L,  0, 26'hC80, 0,        32'h3200, 0, 4, 0);
    add(JR, 0, 0, 32'h3104,       32'h3104, 0, 3, 0);
    add(JR, 0, 0, 32'h3004,       32'h3004, 0, 2, 0);
    add(JR, 0, 0, 32'h3204,       32'h3204, 0, 1, 0);
    add(JR, 0, 0, 32'h3104,       32'h3104, 0, 0, 0);
    add(JR, 0, 0, 32'h3104,       32'h3104, 0, 0, 1);
    add(L,  0, 26'hC40, 0,        32'h3100, 0, 1, 0);
    add(JR, 0, 0, 32'h3000,       32'h3000, 0, 0, 1);
    // exception under stall, stall hold, eret
    add(0,     0, 0, 0,           32'h3004, 0, 0, 0);
    add(0,     0, 0, 0,           32'h3008, 0, 0, 0);
    add(S|X,   0, 0, 0,           32'h4180, 32'h3008, 0, 0);
    add(S,     0, 0, 0,           32'h4180, 32'h3008, 0, 0);
    add(S,     0, 0, 0,           32'h4180, 32'h3008, 0, 0);
    add(S|L|E, 0, 26'hC40, 0,     32'h4180, 32'h3008, 0, 0);
    add(E,     0, 0, 0,           32'h3008, 32'h3008, 0, 0);
    // wrap and priority
    add(JR,   0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3008, 0, 1);
    add(0,    0, 0, 0,             32'h0000_0000, 32'h3008, 0, 0);
    add(L|JR, 0, 26'hC40, 32'h3000, 32'h3000,     32'h3008, 0, 1);
    add(L,    0, 26'hC40, 0,        32'h3100,     32'h3008, 1, 0);
    add(L|JR, 0, 26'hC40, 32'h3004, 32'h3004,     32'h3008, 0, 0);
    add(S,    0, 0, 0,              32'h3004,     32'h3008, 0, 0);
    add(R|S,  0, 0, 0,              32'h3000,     0, 0, 0);
    add(R|X,  0, 0, 0,              32'h3000,     0, 0, 0);
    add(X|JR|E, 0, 0, 32'h1234,     32'h4180,     32'h3000, 0, 0);
    add(E,    0, 0, 0,              32'h3000,     32'h3000, 0, 0);
    add(J|B|Z, 16'hFFFC, 26'hC40, 0, 32'h3100,    32'h3000, 0, 0);
    add(0,    0, 0, 0,              32'h3104,     32'h3000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.c[0]; stall = v.c[1]; branch = v.c[2]; bne = v.c[3]; zero = v.c[4];
      jump = v.c[5]; jal = v.c[6]; jr = v.c[7]; exc = v.c[8]; eret = v.c[9];
      imm16 = v.i16; imm26 = v.i26; jr_target = v.jt;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      exp_pc4 = e.ia + 32'd4;
      chk("iaddr", i, iaddr, e.ia);
      chk("pc4", i, pc4, exp_pc4);
      chk("epc", i, epc, e.ep);
      chk("ras_count", i, {29'd0, ras_count}, e.cnt[31:0]);
      chk("ras_miss", i, {31'd0, ras_miss}, {31'd0, e.miss});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
